barrier_ctrl: RTL and testbench
===============================

Name: barrier_ctrl

Overview:
- Per-core barrier manager; consumes the barrier descriptor (valid, id, is_global, size_m1) issued by the GPU unit for each warp executing a BAR instruction.
- Tracks arrivals per barrier id and stalls the arriving warps. Releases them to the warp scheduler when a local barrier fills.
- For global barriers, forwards one request per id to the cluster-level barrier. Releases the waiting warps when the cluster responds.

Parameters:
NUM_WARPS, 4, warps per core; NW_BITS = clog2(NUM_WARPS), min 1
NUM_BARRIERS, 4, barrier ids; NB_BITS = clog2(NUM_BARRIERS), min 1
SIZE_W, 2, width of size_m1 = max(NW_BITS, NC_BITS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
active_warps  in  NUM_WARPS  warps currently alive on the core
bar_valid  in  1  barrier arrival strobe, one per cycle, always accepted
bar_wid  in  NW_BITS  arriving warp
bar_id  in  NB_BITS  barrier id
bar_is_global  in  1  1 = cluster-wide barrier
bar_size_m1  in  SIZE_W  local: participating warps-1; global: participating cores-1
stalled_warps  out  NUM_WARPS  warps currently held at any barrier
release_valid  out  1  one-cycle pulse: warps released
release_mask  out  NUM_WARPS  warps released this cycle
gbar_req_valid  out  1  global barrier request
gbar_req_id  out  NB_BITS  global barrier id
gbar_req_size_m1  out  SIZE_W  core count-1
gbar_req_ready  in  1  cluster accepts request
gbar_rsp_valid  in  1  cluster releases a global barrier
gbar_rsp_id  in  NB_BITS  released global id

Behaviour:
- Reset clears all outputs to 0, along with all per-id state:
  - lcount[id], lmask[id]
  - gmask[id], gsize[id]
  - req-pending queue/state
- Local arrival (bar_valid & !is_global):
  - If lcount[id] == size_m1: next cycle release_valid=1, release_mask = lmask[id] | onehot(wid); lcount[id] and lmask[id] clear.
  - Else lcount[id]++ and lmask[id] |= onehot(wid).
  - size_m1 = 0 releases the arriving warp alone, one cycle later.
- Global arrival (bar_valid & is_global): gmask[id] |= onehot(wid); gsize[id] = size_m1.
  - When (gmask[id] | onehot(wid)) covers active_warps, id enters a pending-request FIFO of depth NUM_BARRIERS.
  - Each id enqueues at most once per barrier instance.
- gbar_req:
  - Valid/ready. Head of the pending FIFO drives valid, id and size_m1.
  - Outputs are held stable until ready; the entry pops on valid&ready.
  - Enqueue and pop in the same cycle are both honoured.
- gbar_rsp_valid: next cycle release_valid=1, release_mask includes gmask[rsp_id]; gmask[rsp_id] clears. A response for an id with an empty gmask is a no-op.
- Simultaneous local release and global response in one cycle: release_mask is the OR of both masks, in a single pulse.
- stalled_warps:
  - Registered. Equals the OR of all lmask and gmask after the current cycle's updates.
  - A warp's bit rises the cycle after arrival. It falls in the same cycle its release pulse is asserted.
  - The warp that completes a local barrier never appears in stalled_warps.
- Arrival from a warp already in stalled_warps is illegal; flag it with an assertion, and the state is left unchanged.
- A warp leaving active_warps while held is not auto-released. Clearing such a warp is the scheduler's responsibility.
- lcount width is SIZE_W. A count never wraps, because release occurs at equality.
- Reset mid-operation drops all held warps and pending requests. No release pulse is issued for them.

Test Plan:
- NUM_WARPS=4, local id 1, size_m1=3; warps 0,1,2 arrive cycles 0-2:
  - stalled_warps = 0001, 0011, 0111.
  - Warp 3 arrives at cycle 3; cycle 4: release_valid=1, release_mask=1111, stalled_warps=0000.
- Local size_m1=0, warp 2 at id 0 -> next cycle release_mask=0100; stalled_warps stays 0000 throughout.
- Global id 2, size_m1=1, active_warps=0011, warps 0 and 1 arrive:
  - gbar_req_valid=1 with id=2, size_m1=1; ready held low 3 cycles -> req stays stable.
  - ready=1 pops; gbar_rsp_valid id=2 -> next cycle release_mask=0011.
- Local id 0 completing (warps 0,1, size_m1=1) in the same cycle as gbar_rsp for id 3 holding warp 2 -> single pulse, release_mask=0111.
- Interleaved ids: warp 0 at local id 0 and warp 1 at local id 1, each size_m1=1; warp 2 at id 0 -> release 0101 only, warp 1 still stalled.
- Warps 0,1 held at local id 0 (size_m1=3), assert reset 1 cycle -> all outputs 0, no release pulse; fresh barrier then completes normally.

Source files
------------

// File: rtl/barrier_ctrl_if.sv
// Barrier arrival strobe plus the cluster-level global-barrier request/response handshake.
interface barrier_ctrl_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int SIZE_W       = 2
);
  localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  logic               bar_valid;
  logic [NW_BITS-1:0] bar_wid;
  logic [NB_BITS-1:0] bar_id;
  logic               bar_is_global;
  logic [SIZE_W-1:0]  bar_size_m1;

  logic               gbar_req_valid;
  logic [NB_BITS-1:0] gbar_req_id;
  logic [SIZE_W-1:0]  gbar_req_size_m1;
  logic               gbar_req_ready;

  logic               gbar_rsp_valid;
  logic [NB_BITS-1:0] gbar_rsp_id;

  modport master (
    output bar_valid, bar_wid, bar_id, bar_is_global, bar_size_m1,
    output gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    input  gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );

  modport slave (
    input  bar_valid, bar_wid, bar_id, bar_is_global, bar_size_m1,
    input  gbar_req_ready, gbar_rsp_valid, gbar_rsp_id,
    output gbar_req_valid, gbar_req_id, gbar_req_size_m1
  );
endinterface

// File: rtl/barrier_ctrl.sv
// Per-core barrier manager: holds arriving warps per barrier id, releases filled local
// barriers, and forwards fully-arrived global barriers to the cluster via a pending FIFO.
module barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int SIZE_W       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] active_warps,
  barrier_ctrl_if.slave        bus,
  output logic [NUM_WARPS-1:0] stalled_warps,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_mask
);
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
  localparam int CNT_W   = $clog2(NUM_BARRIERS + 1);

  typedef logic [NUM_WARPS-1:0] wmask_t;

  // Per-id barrier state
  logic [SIZE_W-1:0]     lcount   [NUM_BARRIERS];
  wmask_t                lmask    [NUM_BARRIERS];
  wmask_t                gmask    [NUM_BARRIERS];
  logic [SIZE_W-1:0]     gsize    [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] gqueued;

  logic [SIZE_W-1:0]     lcount_n [NUM_BARRIERS];
  wmask_t                lmask_n  [NUM_BARRIERS];
  wmask_t                gmask_n  [NUM_BARRIERS];
  logic [SIZE_W-1:0]     gsize_n  [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] gqueued_n;

  // Pending global-request FIFO (ids only; size is looked up from gsize)
  logic [NB_BITS-1:0]    fifo_id  [NUM_BARRIERS];
  logic [NB_BITS-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      fifo_cnt;

  wmask_t                wid_oh, stalled_n, rel_mask_n, rel_mask_p1, stalled_p1;
  logic                  arr_ok, rel_vld_n, rel_vld_p1, enq, pop, req_vld;
  logic [NB_BITS-1:0]    head_id;

  function automatic logic [NB_BITS-1:0] ptr_inc(input logic [NB_BITS-1:0] p);
    return (p == NB_BITS'(NUM_BARRIERS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_vld = (fifo_cnt != '0);
  assign head_id = fifo_id[rd_ptr];
  assign pop     = req_vld && bus.gbar_req_ready;

  // Stage p0: next-state of all per-id barrier state for this cycle's events
  always_comb begin
    lcount_n   = lcount;
    lmask_n    = lmask;
    gmask_n    = gmask;
    gsize_n    = gsize;
    gqueued_n  = gqueued;
    rel_vld_n  = 1'b0;
    rel_mask_n = '0;
    enq        = 1'b0;
    wid_oh     = '0;
    wid_oh[bus.bar_wid] = 1'b1;
    // An arrival from an already-held warp is ignored (flagged by the assertion below).
    arr_ok = bus.bar_valid && !stalled_warps[bus.bar_wid];

    if (arr_ok && !bus.bar_is_global) begin
      if (lcount[bus.bar_id] == bus.bar_size_m1) begin
        rel_vld_n  = 1'b1;
        rel_mask_n = lmask[bus.bar_id] | wid_oh;
        lcount_n[bus.bar_id] = '0;
        lmask_n[bus.bar_id]  = '0;
      end else begin
        lcount_n[bus.bar_id] = lcount[bus.bar_id] + 1'b1;
        lmask_n[bus.bar_id]  = lmask[bus.bar_id] | wid_oh;
      end
    end

    if (bus.gbar_rsp_valid && (gmask[bus.gbar_rsp_id] != '0)) begin
      rel_vld_n  = 1'b1;
      rel_mask_n = rel_mask_n | gmask[bus.gbar_rsp_id];
      gmask_n[bus.gbar_rsp_id]   = '0;
      gqueued_n[bus.gbar_rsp_id] = 1'b0;
    end

    if (arr_ok && bus.bar_is_global) begin
      gmask_n[bus.bar_id] = gmask_n[bus.bar_id] | wid_oh;
      gsize_n[bus.bar_id] = bus.bar_size_m1;
      if (!gqueued_n[bus.bar_id] && ((active_warps & ~gmask_n[bus.bar_id]) == '0)
          && ((fifo_cnt != CNT_W'(NUM_BARRIERS)) || pop)) begin
        enq = 1'b1;
        gqueued_n[bus.bar_id] = 1'b1;
      end
    end

    stalled_n = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled_n = stalled_n | lmask_n[b] | gmask_n[b];
    end
  end

  // Stage p1: registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      lcount      <= '{default: '0};
      lmask       <= '{default: '0};
      gmask       <= '{default: '0};
      gsize       <= '{default: '0};
      gqueued     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      rel_vld_p1  <= 1'b0;
      rel_mask_p1 <= '0;
      stalled_p1  <= '0;
    end else begin
      lcount      <= lcount_n;
      lmask       <= lmask_n;
      gmask       <= gmask_n;
      gsize       <= gsize_n;
      gqueued     <= gqueued_n;
      rel_vld_p1  <= rel_vld_n;
      rel_mask_p1 <= rel_mask_n;
      stalled_p1  <= stalled_n;
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_id[wr_ptr] <= bus.bar_id;
  end

  assign stalled_warps        = stalled_p1;
  assign release_valid        = rel_vld_p1;
  assign release_mask         = rel_mask_p1;
  assign bus.gbar_req_valid   = req_vld;
  assign bus.gbar_req_id      = req_vld ? head_id : '0;
  assign bus.gbar_req_size_m1 = req_vld ? gsize[head_id] : '0;

  illegal_arrival: assert property (@(posedge clk) disable iff (reset)
    bus.bar_valid |-> !stalled_warps[bus.bar_wid]);
endmodule

// File: tb/tb_barrier_ctrl.sv
// Directed and randomized bench for barrier_ctrl against a set/queue-based reference model.
module tb_barrier_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] active_warps;
  logic [3:0] stalled_warps, release_mask;
  logic       release_valid;

  barrier_ctrl_if #(.NUM_WARPS(4), .NUM_BARRIERS(4), .SIZE_W(2)) bus ();

  barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4), .SIZE_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .active_warps (active_warps),
    .bus          (bus.slave),
    .stalled_warps(stalled_warps),
    .release_valid(release_valid),
    .release_mask (release_mask)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: sets of waiting warps per id, plus a queue of pending global ids.
  bit [3:0] lm [4];
  bit [3:0] gm [4];
  bit [1:0] gs [4];
  bit       gq [4];
  int       ls [4];
  int       pend [$];
  bit       e_rv;
  bit [3:0] e_rm, e_stall;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit [3:0] oh, rm;
    bit       rv, pop;
    int       id, r;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        lm[i] = 0; gm[i] = 0; gs[i] = 0; gq[i] = 0;
      end
      pend.delete();
      e_rv = 0; e_rm = 0; e_stall = 0;
    end else begin
      rm  = 0;
      rv  = 0;
      oh  = 4'b0001 << bus.bar_wid;
      id  = int'(bus.bar_id);
      pop = (pend.size() > 0) && bus.gbar_req_ready;
      if (bus.bar_valid && !bus.bar_is_global) begin
        if ($countones(lm[id]) == int'(bus.bar_size_m1)) begin
          rv = 1; rm = rm | lm[id] | oh; lm[id] = 0;
        end else begin
          lm[id] = lm[id] | oh;
        end
      end
      r = int'(bus.gbar_rsp_id);
      if (bus.gbar_rsp_valid && gm[r] != 0) begin
        rv = 1; rm = rm | gm[r]; gm[r] = 0; gq[r] = 0;
      end
      if (pop) void'(pend.pop_front());
      if (bus.bar_valid && bus.bar_is_global) begin
        gm[id] = gm[id] | oh;
        gs[id] = bus.bar_size_m1;
        if (!gq[id] && ((active_warps & ~gm[id]) == 0) && pend.size() < 4) begin
          pend.push_back(id);
          gq[id] = 1;
        end
      end
      e_rv = rv;
      e_rm = rm;
      e_stall = 0;
      for (int i = 0; i < 4; i++) e_stall = e_stall | lm[i] | gm[i];
    end
    @(posedge clk);
    #1;
    chk("release_valid", release_valid, e_rv);
    chk("release_mask", release_mask, e_rm);
    chk("stalled_warps", stalled_warps, e_stall);
    chk("req_valid", bus.gbar_req_valid, pend.size() != 0);
    chk("req_id", bus.gbar_req_id, (pend.size() != 0) ? pend[0] : 0);
    chk("req_size", bus.gbar_req_size_m1, (pend.size() != 0) ? gs[pend[0]] : 0);
    bus.bar_valid      = 1'b0;
    bus.gbar_rsp_valid = 1'b0;
  endtask

  task automatic arrive(int w, int id, bit g, int sz);
    bus.bar_valid     = 1'b1;
    bus.bar_wid       = 2'(w);
    bus.bar_id        = 2'(id);
    bus.bar_is_global = g;
    bus.bar_size_m1   = 2'(sz);
  endtask

  task automatic respond(int id);
    bus.gbar_rsp_valid = 1'b1;
    bus.gbar_rsp_id    = 2'(id);
  endtask

  initial begin
    int  w, id, sz, r;
    bit  g, inq;
    bit [3:0] free;

    reset = 1'b1;
    active_warps = 4'b1111;
    bus.bar_valid = 0; bus.bar_wid = 0; bus.bar_id = 0; bus.bar_is_global = 0;
    bus.bar_size_m1 = 0; bus.gbar_req_ready = 0; bus.gbar_rsp_valid = 0; bus.gbar_rsp_id = 0;
    tick();
    tick();
    chk("reset_stalled", stalled_warps, 4'b0000);
    chk("reset_release", release_valid, 1'b0);
    reset = 1'b0;

    // Local id 1, four participants
    arrive(0, 1, 0, 3); tick(); chk("loc4_stall0", stalled_warps, 4'b0001);
    arrive(1, 1, 0, 3); tick(); chk("loc4_stall1", stalled_warps, 4'b0011);
    arrive(2, 1, 0, 3); tick(); chk("loc4_stall2", stalled_warps, 4'b0111);
    chk("loc4_no_rel", release_valid, 1'b0);
    arrive(3, 1, 0, 3); tick();
    chk("loc4_rel_vld", release_valid, 1'b1);
    chk("loc4_rel_mask", release_mask, 4'b1111);
    chk("loc4_stall3", stalled_warps, 4'b0000);
    tick(); chk("loc4_pulse_end", release_valid, 1'b0);

    // Single-warp local barrier
    arrive(2, 0, 0, 0); tick();
    chk("solo_rel_mask", release_mask, 4'b0100);
    chk("solo_stall", stalled_warps, 4'b0000);
    tick();

    // Global id 2 with two active warps, ready withheld for three cycles
    active_warps = 4'b0011;
    arrive(0, 2, 1, 1); tick(); chk("glb_no_req", bus.gbar_req_valid, 1'b0);
    arrive(1, 2, 1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      chk("glb_req_vld", bus.gbar_req_valid, 1'b1);
      chk("glb_req_id", bus.gbar_req_id, 2);
      chk("glb_req_size", bus.gbar_req_size_m1, 1);
      tick();
    end
    bus.gbar_req_ready = 1'b1; tick(); bus.gbar_req_ready = 1'b0;
    chk("glb_popped", bus.gbar_req_valid, 1'b0);
    chk("glb_stall", stalled_warps, 4'b0011);
    respond(2); tick();
    chk("glb_rel_mask", release_mask, 4'b0011);
    chk("glb_stall_clr", stalled_warps, 4'b0000);
    respond(2); tick();
    chk("glb_empty_rsp", release_valid, 1'b0);

    // Local completion coinciding with a global response
    active_warps = 4'b0100;
    arrive(2, 3, 1, 0); tick();
    bus.gbar_req_ready = 1'b1; tick(); bus.gbar_req_ready = 1'b0;
    active_warps = 4'b1111;
    arrive(0, 0, 0, 1); tick();
    arrive(1, 0, 0, 1); respond(3); tick();
    chk("merge_rel_mask", release_mask, 4'b0111);
    chk("merge_stall", stalled_warps, 4'b0000);
    tick(); chk("merge_one_pulse", release_valid, 1'b0);

    // Interleaved local ids
    arrive(0, 0, 0, 1); tick();
    arrive(1, 1, 0, 1); tick();
    arrive(2, 0, 0, 1); tick();
    chk("ilv_rel_mask", release_mask, 4'b0101);
    chk("ilv_stall", stalled_warps, 4'b0010);
    arrive(3, 1, 0, 1); tick();
    chk("ilv_rel_mask2", release_mask, 4'b1010);

    // Reset mid-barrier drops held warps without a release pulse
    arrive(0, 0, 0, 3); tick();
    arrive(1, 0, 0, 3); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_stall", stalled_warps, 4'b0000);
    chk("rst_rel", release_valid, 1'b0);
    tick(); chk("rst_no_pulse", release_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      arrive(i, 0, 0, 3); tick();
    end
    chk("rst_fresh_mask", release_mask, 4'b1111);

    // Randomized traffic: ids 0/1 local, ids 2/3 global, all warps active
    for (int i = 0; i < 4; i++) ls[i] = 0;
    for (int c = 0; c < 800; c++) begin
      bus.gbar_req_ready = 1'($urandom_range(0, 1));
      if (e_stall == 4'b1111 && gm[2] == 0 && gm[3] == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
        continue;
      end
      free = ~e_stall;
      if (free != 0 && $urandom_range(0, 2) != 0) begin
        do w = $urandom_range(0, 3); while (!free[w]);
        g = ($urandom_range(0, 2) == 0);
        if (g) begin
          id = 2 + $urandom_range(0, 1);
          sz = $urandom_range(0, 3);
        end else begin
          id = $urandom_range(0, 1);
          if (lm[id] == 0) ls[id] = $urandom_range(0, 3);
          sz = ls[id];
        end
        arrive(w, id, g, sz);
      end
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 3);
        inq = 0;
        foreach (pend[k]) if (pend[k] == r) inq = 1;
        if (!inq) respond(r);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
